// File: rtl/shift_sequencer.sv
// Iterative shift unit. It accepts one request over a valid/ready handshake
// and shifts the operand by at most STEP bits per cycle. The result is held
// on a second valid/ready handshake until the consumer takes it.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [31:0]      shamt,
  input  logic [1:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  // The remaining count must be able to hold WIDTH itself.
  // The per-cycle step count must be able to hold STEP itself.
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(STEP + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg;
  logic [CW-1:0]    rem_reg;
  logic             left_reg;
  logic             arith_reg;
  logic             sign_reg;

  logic             accept;
  logic [CW-1:0]    n_clamped;
  logic [SW-1:0]    step_amt;
  logic [WIDTH-1:0] step_cand [0:STEP];

  assign accept = in_valid && (state_reg == IDLE);

  // A full 32-bit compare keeps large shift amounts from wrapping modulo WIDTH.
  assign n_clamped = (shamt >= 32'(WIDTH)) ? CW'(WIDTH) : shamt[CW-1:0];

  // Take a full STEP while enough bits remain. Otherwise take only the remainder.
  assign step_amt = (rem_reg < CW'(STEP)) ? rem_reg[SW-1:0] : SW'(STEP);

  // The narrow shifter builds one candidate per legal step size, 0..STEP.
  // A right shift fills its vacated upper bits with the sign latched at
  // acceptance, but only for arithmetic ops.
  generate
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_step
      logic [WIDTH-1:0] fill_mask;
      assign fill_mask     = (arith_reg && sign_reg) ? ~({WIDTH{1'b1}} >> gi) : '0;
      assign step_cand[gi] = left_reg ? (work_reg << gi) : ((work_reg >> gi) | fill_mask);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. A zero-length shift skips SHIFT entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = (n_clamped == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_reg <= CW'(STEP)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the request on acceptance, then advance one step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_reg  <= '0;
      rem_reg   <= '0;
      left_reg  <= 1'b0;
      arith_reg <= 1'b0;
      sign_reg  <= 1'b0;
    end else if (accept) begin
      work_reg  <= a;
      rem_reg   <= n_clamped;
      left_reg  <= ALUop[1];
      arith_reg <= ALUop[0];
      sign_reg  <= a[WIDTH-1];
    end else if (state_reg == SHIFT) begin
      work_reg  <= step_cand[step_amt];
      rem_reg   <= rem_reg - CW'(step_amt);
    end
  end

  // Outputs are decoded from state only, so no input reaches an output combinationally.
  // result is masked outside DONE, so partial values are never visible.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = (state_reg == DONE) ? work_reg : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus short random bench for shift_sequencer. Each expected result
// is pushed to a scoreboard queue when its request is driven. It is popped
// and checked when out_valid appears.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] shamt;
  logic [1:0]  ALUop;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    int          shifts;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .ALUop     (ALUop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a plain shift with the amount clamped to 32, computed in 64 bits.
  function automatic logic [31:0] model_res(input logic [31:0] av, input logic [31:0] sh,
                                            input logic [1:0] op);
    int          n;
    logic [63:0] t;
    n = (sh >= 32) ? 32 : int'(sh);
    if (op[1])      t = {32'b0, av} << n;
    else if (op[0]) t = {{32{av[31]}}, av} >> n;
    else            t = {32'b0, av} >> n;
    return t[31:0];
  endfunction

  // Expected number of SHIFT cycles, ceil(n/4), where 0 means SHIFT is skipped.
  function automatic int model_shifts(input logic [31:0] sh);
    int n;
    n = (sh >= 32) ? 32 : int'(sh);
    return (n == 0) ? 0 : (n + 3) / 4;
  endfunction

  // Called at a negedge with the DUT idle. It returns at the negedge after the acceptance edge.
  task automatic issue(input string tag, input logic [31:0] av, input logic [31:0] sh,
                       input logic [1:0] op, input logic [31:0] exp_res, input int exp_sh,
                       input bit track);
    exp_t e;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; shamt = sh; ALUop = op; in_valid = 1'b1;
    if (track) begin
      e.res = exp_res; e.shifts = exp_sh; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; shamt = $urandom; ALUop = 2'($urandom);
  endtask

  // Starts at the first negedge after acceptance. It counts SHIFT cycles until out_valid is seen.
  task automatic collect(input string tag);
    exp_t e;
    int   shifts;
    bit   busy_low;
    shifts = 0;
    busy_low = 1'b0;
    while (out_valid !== 1'b1 && shifts < 40) begin
      if (busy !== 1'b1) busy_low = 1'b1;
      @(negedge clk);
      shifts++;
    end
    if (busy !== 1'b1) busy_low = 1'b1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_result"}, result, e.res);
      check({e.tag, "_shift_cycles"}, 32'(shifts), 32'(e.shifts));
    end
    check({tag, "_busy_low_seen"}, 32'(busy_low), 32'd0);
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
    $display("txn %s shift_cycles=%0d result=%h", tag, shifts, result);
  endtask

  // Consumer takes the result. The DUT must then sit in IDLE with clean outputs.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_result"}, result, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra, rs;
    logic [1:0]  ro;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; shamt = '0; ALUop = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Arithmetic right across two steps, then backpressure with a queued request.
    issue("asr5", 32'h80000001, 32'd5, 2'b01, 32'hFC000000, 2, 1'b1);
    collect("asr5");
    a = 32'h000000FF; shamt = 32'd8; ALUop = 2'b10; in_valid = 1'b1;
    e.res = 32'h0000FF00; e.shifts = 2; e.tag = "bp_next";
    sb.push_back(e);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_result", result, 32'hFC000000);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    collect("bp_next");
    drain("bp_next");

    // Left shift at a STEP multiple. The logical and arithmetic op codes must match.
    issue("lsl8", 32'h000000FF, 32'd8, 2'b10, 32'h0000FF00, 2, 1'b1);
    collect("lsl8");
    drain("lsl8");
    issue("lsl8_arith", 32'h000000FF, 32'd8, 2'b11, 32'h0000FF00, 2, 1'b1);
    collect("lsl8_arith");
    drain("lsl8_arith");

    // Clamp at and beyond WIDTH.
    issue("clamp_asr40", 32'h80000000, 32'd40, 2'b01, 32'hFFFFFFFF, 8, 1'b1);
    collect("clamp_asr40");
    drain("clamp_asr40");
    issue("clamp_lsr40", 32'h80000000, 32'd40, 2'b00, 32'h00000000, 8, 1'b1);
    collect("clamp_lsr40");
    drain("clamp_lsr40");
    issue("clamp_asr_max", 32'h80000000, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, 8, 1'b1);
    collect("clamp_asr_max");
    drain("clamp_asr_max");
    issue("clamp_lsl33", 32'h00000001, 32'd33, 2'b10, 32'h00000000, 8, 1'b1);
    collect("clamp_lsl33");
    drain("clamp_lsl33");

    // Zero shift: result appears the cycle after acceptance.
    issue("zero", 32'h12345678, 32'd0, 2'b00, 32'h12345678, 0, 1'b1);
    collect("zero");
    drain("zero");

    // Reset during the third SHIFT cycle discards the operation.
    issue("rst_mid", 32'hFFFF0000, 32'd20, 2'b00, 32'h0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_result", result, 32'd0);
    $display("txn rst_mid aborted in_ready=%0b busy=%0b", in_ready, busy);
    issue("post_rst", 32'hFFFF0000, 32'd20, 2'b00, 32'h00000FFF, 5, 1'b1);
    collect("post_rst");
    drain("post_rst");

    // Short random run against the reference.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rs = (i == 7) ? $urandom : 32'($urandom_range(0, 40));
      ro = 2'($urandom);
      issue("rnd", ra, rs, ro, model_res(ra, rs, ro), model_shifts(rs), 1'b1);
      collect("rnd");
      drain("rnd");
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
